// File: rtl/tx_arb_pkg.sv
// Package: tx_arb_pkg
// Shared types and helpers for the TX stream arbiter.
//   src_e       : encoding of the source of an output beat (tx_sel)
//   arb_state_e : arbiter FSM state
//   arbitrate() : fixed-priority pick SKP > OS > DL
//   state_to_src(): map a granted state onto its tx_sel encoding
package tx_arb_pkg;

  typedef enum logic [1:0] {
    SRC_OS   = 2'd0,
    SRC_SKP  = 2'd1,
    SRC_DL   = 2'd2,
    SRC_IDLE = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OS   = 2'd1,
    SKP  = 2'd2,
    DL   = 2'd3
  } arb_state_e;

  // Inputs are already qualified (SKP needs pending>0, DL needs link_up).
  function automatic arb_state_e arbitrate(input logic skp_ok,
                                           input logic os_ok,
                                           input logic dl_ok);
    arb_state_e pick;
    pick = IDLE;
    if (skp_ok)     pick = SKP;
    else if (os_ok) pick = OS;
    else if (dl_ok) pick = DL;
    return pick;
  endfunction

  function automatic src_e state_to_src(input arb_state_e s);
    src_e sel;
    case (s)
      OS:      sel = SRC_OS;
      SKP:     sel = SRC_SKP;
      DL:      sel = SRC_DL;
      default: sel = SRC_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tx_stream_arbiter_skp_pend_ctr.sv
// Module: skp_pend_ctr
// Saturating up/down counter of SKP ordered sets that are due but not yet sent,
// plus a sticky overflow flag.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   inc        : one more SKP is due (skp_tick)
//   dec        : the last beat of an SKP was accepted
//   count      : pending SKP count, saturates at 2**W-1
//   overflow   : sticky, set when inc arrives with count saturated
module skp_pend_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      // A tick that cannot be counted is lost; remember that it happened.
      if (count == CNT_MAX) overflow <= 1'b1;
      else                  count    <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
    // inc && dec together: one SKP due, one sent -> count unchanged.
  end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Module: tx_stream_arbiter
// Shares the PHY TX datapath between the ordered-set creator (OS), the SKP
// generator (SKP) and the data link layer (DL). Grants change only on packet
// boundaries, so SKP is only ever inserted between packets.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   back_pressure            : PIPE stall, nothing is accepted while high
//   link_up                  : enables new DL grants
//   skp_tick                 : one more SKP ordered set is due
//   os_/skp_/dl_ valid,last,data,k : source beats;  *_ready : beat accepted
//   tx_valid,tx_data,tx_k    : registered output beat
//   tx_sel                   : source of the output beat (src_e)
//   tx_pkt_start             : output beat is the first beat of a packet
//   skp_done                 : pulse, last SKP beat was accepted
//   skp_overflow             : sticky, SKP tick lost at saturated pending count
//   state_dbg                : arbiter FSM state
//   skp_pend                 : pending SKP count
// Build option: ARB_IDLE_FILL_EN -- when defined, cycles without an accepted
// beat (no stall, link up) output a logical-idle beat (tx_valid=1, zero data,
// tx_sel=SRC_IDLE). Undefined: such cycles output tx_valid=0.
//
// Handshake: a beat transfers when <src>_valid & <src>_ready. <src>_ready is
// combinational: high when that source holds (or, from IDLE, wins) the grant,
// back_pressure is low and rst is high. From IDLE, ready depends on the
// source's own valid through arbitration; sources must not wait for ready
// before raising valid.
module tx_stream_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int MAX_LANES  = 32,
  parameter int SKP_PEND_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  back_pressure,
  input  logic                  link_up,
  input  logic                  skp_tick,
  input  logic                  os_valid,
  input  logic                  os_last,
  input  logic [DATA_WIDTH-1:0] os_data,
  input  logic [MAX_LANES-1:0]  os_k,
  output logic                  os_ready,
  input  logic                  skp_valid,
  input  logic                  skp_last,
  input  logic [DATA_WIDTH-1:0] skp_data,
  input  logic [MAX_LANES-1:0]  skp_k,
  output logic                  skp_ready,
  input  logic                  dl_valid,
  input  logic                  dl_last,
  input  logic [DATA_WIDTH-1:0] dl_data,
  input  logic [MAX_LANES-1:0]  dl_k,
  output logic                  dl_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [MAX_LANES-1:0]  tx_k,
  output src_e                  tx_sel,
  output logic                  tx_pkt_start,
  output logic                  skp_done,
  output logic                  skp_overflow,
  output arb_state_e            state_dbg,
  output logic [SKP_PEND_W-1:0] skp_pend
);

  arb_state_e            state;
  arb_state_e            grant;
  arb_state_e            next_grant;
  logic                  started;   // a beat of the current grant was accepted
  logic                  skp_elig;
  logic                  dl_elig;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [MAX_LANES-1:0]  cur_k;
  logic                  acc;
  logic                  pkt_start;
  logic                  skp_dec;

  assign skp_elig  = (skp_pend != '0) & skp_valid;
  assign dl_elig   = dl_valid & link_up;
  assign state_dbg = state;

  always_comb begin
    // From IDLE the winner is granted in the same cycle.
    grant = state;
    if (state == IDLE) grant = arbitrate(skp_elig, os_valid, dl_elig);

    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    cur_k     = '0;
    case (grant)
      OS:  begin cur_valid = os_valid;  cur_last = os_last;  cur_data = os_data;  cur_k = os_k;  end
      SKP: begin cur_valid = skp_valid; cur_last = skp_last; cur_data = skp_data; cur_k = skp_k; end
      DL:  begin cur_valid = dl_valid;  cur_last = dl_last;  cur_data = dl_data;  cur_k = dl_k;  end
      default: ;
    endcase

    acc       = rst & ~back_pressure & cur_valid;
    pkt_start = acc & ((state == IDLE) | ~started);
    skp_dec   = acc & cur_last & (grant == SKP);

    // Re-arbitration for the cycle after a last beat. The finishing source's
    // valid belongs to the beat being consumed now, so it cannot claim the
    // next packet; masking it also lets the other sources take their turn.
    next_grant = arbitrate(skp_elig & (grant != SKP),
                           os_valid & (grant != OS),
                           dl_elig  & (grant != DL));

    os_ready  = rst & ~back_pressure & (grant == OS);
    skp_ready = rst & ~back_pressure & (grant == SKP);
    dl_ready  = rst & ~back_pressure & (grant == DL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      started      <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      tx_k         <= '0;
      tx_sel       <= SRC_OS;
      tx_pkt_start <= 1'b0;
      skp_done     <= 1'b0;
    end else begin
      if (acc) begin
        if (cur_last) begin
          state   <= next_grant;
          started <= 1'b0;
        end else begin
          state   <= grant;
          started <= 1'b1;
        end
      end

      tx_valid     <= acc;
      tx_data      <= acc ? cur_data : '0;
      tx_k         <= acc ? cur_k : '0;
      tx_sel       <= acc ? state_to_src(grant) : SRC_OS;
      tx_pkt_start <= pkt_start;
      skp_done     <= skp_dec;
`ifdef ARB_IDLE_FILL_EN
      if (!acc && !back_pressure && link_up) begin
        tx_valid <= 1'b1;
        tx_sel   <= SRC_IDLE;
      end
`endif
    end
  end

  skp_pend_ctr #(
    .W(SKP_PEND_W)
  ) u_skp_pend_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (skp_tick),
    .dec      (skp_dec),
    .count    (skp_pend),
    .overflow (skp_overflow)
  );

endmodule

// File: tb/tb_tx_stream_arbiter.sv
module tb_tx_stream_arbiter;
  import tx_arb_pkg::*;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int EW = 1 + 2 + KW + DW;  // {pkt_start, sel, k, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          back_pressure, link_up, skp_tick;
  logic          os_valid, os_last, os_ready;
  logic [DW-1:0] os_data;
  logic [KW-1:0] os_k;
  logic          skp_valid, skp_last, skp_ready;
  logic [DW-1:0] skp_data;
  logic [KW-1:0] skp_k;
  logic          dl_valid, dl_last, dl_ready;
  logic [DW-1:0] dl_data;
  logic [KW-1:0] dl_k;
  logic          tx_valid, tx_pkt_start, skp_done, skp_overflow;
  logic [DW-1:0] tx_data;
  logic [KW-1:0] tx_k;
  src_e          tx_sel;
  arb_state_e    state_dbg;
  logic [2:0]    skp_pend;

  tx_stream_arbiter dut (
    .clk(clk), .rst(rst), .back_pressure(back_pressure), .link_up(link_up),
    .skp_tick(skp_tick),
    .os_valid(os_valid), .os_last(os_last), .os_data(os_data), .os_k(os_k), .os_ready(os_ready),
    .skp_valid(skp_valid), .skp_last(skp_last), .skp_data(skp_data), .skp_k(skp_k),
    .skp_ready(skp_ready),
    .dl_valid(dl_valid), .dl_last(dl_last), .dl_data(dl_data), .dl_k(dl_k), .dl_ready(dl_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_k(tx_k), .tx_sel(tx_sel),
    .tx_pkt_start(tx_pkt_start), .skp_done(skp_done), .skp_overflow(skp_overflow),
    .state_dbg(state_dbg), .skp_pend(skp_pend)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic logic [DW-1:0] mk_data(input int src, input int idx);
    return {8{8'(src), 8'(idx), 16'h5aa5}};
  endfunction

  function automatic logic [KW-1:0] mk_k(input int src, input int idx);
    return {8'(src), 8'(idx), 16'h0f0f};
  endfunction

  task automatic push(input int src, input int idx, input logic start);
    exp_q.push_back({start, 2'(src), mk_k(src, idx), mk_data(src, idx)});
  endtask

  // Registered-output monitor: every valid output beat must match the queue head.
  task automatic mon();
    logic [EW-1:0] e;
    if (tx_valid) begin
      check("tx_beat_expected", {255'b0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_data", tx_data, e[DW-1:0]);
        check("tx_k", tx_k, e[DW+KW-1:DW]);
        check("tx_sel", tx_sel, e[DW+KW+1:DW+KW]);
        check("tx_pkt_start", tx_pkt_start, e[EW-1]);
      end
    end
  endtask

  // One clock: advance past the edge, then sample registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear();
    os_valid = 0; os_last = 0; os_data = '0; os_k = '0;
    skp_valid = 0; skp_last = 0; skp_data = '0; skp_k = '0;
    dl_valid = 0; dl_last = 0; dl_data = '0; dl_k = '0;
  endtask

  task automatic put(input int src, input logic last, input int idx);
    case (src)
      0: begin os_valid = 1; os_last = last; os_data = mk_data(0, idx); os_k = mk_k(0, idx); end
      1: begin skp_valid = 1; skp_last = last; skp_data = mk_data(1, idx); skp_k = mk_k(1, idx); end
      default: begin dl_valid = 1; dl_last = last; dl_data = mk_data(2, idx); dl_k = mk_k(2, idx); end
    endcase
  endtask

  // Present one beat, check its ready, record the expected output, clock.
  task automatic beat(input int src, input logic last, input int idx,
                      input logic start, input logic exp_rdy);
    logic rdy;
    put(src, last, idx);
    #1;
    rdy = (src == 0) ? os_ready : (src == 1) ? skp_ready : dl_ready;
    check($sformatf("ready_src%0d_beat%0d", src, idx), {255'b0, rdy}, {255'b0, exp_rdy});
    if (exp_rdy) push(src, idx, start);
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 0; back_pressure = 0; link_up = 0; skp_tick = 0;
    clear();
    os_valid = 1;
    #1;
    check("rst_os_ready", {255'b0, os_ready}, 0);
    tick(); tick();
    check("rst_tx_valid", {255'b0, tx_valid}, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_pend", skp_pend, 0);
    check("rst_overflow", {255'b0, skp_overflow}, 0);
    clear();
    rst = 1;
    tick();

    // 1: 3-beat OS
    for (int i = 0; i < 3; i++) beat(0, i == 2, i, i == 0, 1);
    clear();
    check("t1_state_idle", state_dbg, IDLE);
    tick();

    // 2: 4-beat DL, skp_tick during the second beat, SKP follows back-to-back
    link_up = 1;
    skp_valid = 1; skp_last = 1; skp_data = mk_data(1, 0); skp_k = mk_k(1, 0);
    beat(2, 0, 0, 1, 1);
    skp_tick = 1;
    beat(2, 0, 1, 0, 1);
    skp_tick = 0;
    check("t2_pend_1", skp_pend, 1);
    beat(2, 0, 2, 0, 1);
    check("t2_skp_ready_held_off", {255'b0, skp_ready}, 0);
    beat(2, 1, 3, 0, 1);
    dl_valid = 0; dl_last = 0;
    check("t2_state_skp", state_dbg, SKP);
    beat(1, 1, 0, 1, 1);
    clear();
    check("t2_skp_done", {255'b0, skp_done}, 1);
    check("t2_pend_0", skp_pend, 0);
    tick();
    check("t2_skp_done_once", {255'b0, skp_done}, 0);

    // 3a: OS and DL both valid in IDLE -> OS first, DL next
    put(0, 1, 5);
    put(2, 1, 5);
    #1;
    check("t3_dl_ready_waits", {255'b0, dl_ready}, 0);
    beat(0, 1, 5, 1, 1);
    os_valid = 0; os_last = 0;
    check("t3_state_dl", state_dbg, DL);
    beat(2, 1, 5, 1, 1);
    clear();
    // 3b: link down -> DL never granted
    link_up = 0;
    for (int i = 0; i < 3; i++) beat(2, 1, 6, 1, 0);
    check("t3_state_idle_link_down", state_dbg, IDLE);
    clear();
    link_up = 1;
    tick();

    // 4: 8 SKP ticks with no SKP source -> saturate and sticky overflow
    for (int i = 0; i < 8; i++) begin
      skp_tick = 1;
      tick();
      if (i == 6) check("t4_overflow_not_yet", {255'b0, skp_overflow}, 0);
    end
    skp_tick = 0;
    check("t4_pend_sat", skp_pend, 7);
    check("t4_overflow", {255'b0, skp_overflow}, 1);
    tick(); tick();
    check("t4_overflow_sticky", {255'b0, skp_overflow}, 1);
    // tick and SKP completion together at max -> unchanged; then plain completion
    skp_tick = 1;
    beat(1, 1, 1, 1, 1);
    skp_tick = 0;
    check("t4_pend_inc_dec", skp_pend, 7);
    beat(1, 1, 2, 1, 1);
    clear();
    check("t4_pend_dec", skp_pend, 6);
    tick();

    // 5: back_pressure for 5 cycles mid-OS
    beat(0, 0, 0, 1, 1);
    beat(0, 0, 1, 0, 1);
    back_pressure = 1;
    for (int i = 0; i < 5; i++) begin
      beat(0, 0, 2, 0, 0);
      check("t5_tx_valid_stall", {255'b0, tx_valid}, 0);
    end
    check("t5_state_os", state_dbg, OS);
    back_pressure = 0;
    for (int i = 2; i < 6; i++) beat(0, i == 5, i, 0, 1);
    clear();
    tick();

    // 6: reset mid-DL, then a fresh packet
    beat(2, 0, 0, 1, 1);
    beat(2, 0, 1, 0, 1);
    rst = 0;
    put(2, 0, 2);
    #1;
    check("t6_dl_ready_in_rst", {255'b0, dl_ready}, 0);
    tick();
    check("t6_tx_valid", {255'b0, tx_valid}, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_pkt_start", {255'b0, tx_pkt_start}, 0);
    check("t6_state", state_dbg, IDLE);
    check("t6_pend", skp_pend, 0);
    check("t6_overflow_cleared", {255'b0, skp_overflow}, 0);
    rst = 1;
    clear();
    beat(2, 1, 9, 1, 1);
    clear();
    tick(); tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
